// File: rtl/serial_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared types and constants for the serial link receive path.
//   state_t    : deserializer FSM states (PARITY only reachable when the
//                SERIAL_DESER_PARITY_EN macro is defined)
//   START_BIT  : line level that opens a frame
//   STOP_BIT   : line level required to close a frame
//   IDLE_LEVEL : level the line rests at between frames
//   clog2()    : bits needed to count 0..value-1
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// ---------------------------------------------------------------------------
// serial_deserializer_if
// Bundles the serial input and the word-wide output handshake of the
// deserializer.
//   inp, inp_valid : serial bit and its qualifier (driven by the link)
//   out, out_valid : received word and its valid flag
//   out_ready      : consumer accepts out when out_valid && out_ready
//   frame_err      : one-cycle pulse, stop bit was wrong
//   overrun        : one-cycle pulse, good word dropped (holding reg full)
//   parity_err     : one-cycle pulse, only when SERIAL_DESER_PARITY_EN
// Modports: master = link/consumer side, slave = deserializer side.
// ---------------------------------------------------------------------------
interface serial_deserializer_if #(
  parameter int WIDTH = 8
);

  logic             inp;
  logic             inp_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic             overrun;
`ifdef SERIAL_DESER_PARITY_EN
  logic             parity_err;

  modport master (
    output inp, inp_valid, out_ready,
    input  out, out_valid, frame_err, overrun, parity_err
  );

  modport slave (
    input  inp, inp_valid, out_ready,
    output out, out_valid, frame_err, overrun, parity_err
  );
`else
  modport master (
    output inp, inp_valid, out_ready,
    input  out, out_valid, frame_err, overrun
  );

  modport slave (
    input  inp, inp_valid, out_ready,
    output out, out_valid, frame_err, overrun
  );
`endif

endinterface

// File: rtl/serial_deserializer_word_holding_reg.sv
// ---------------------------------------------------------------------------
// word_holding_reg
// One-entry output register with valid/ready handshake. A word offered on
// load is taken if the register is empty or being drained in the same
// cycle; otherwise it is dropped and overrun pulses for one cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   load, din  : new word offer
//   ready      : consumer accepts dout when valid && ready
//   dout       : held word (keeps its last value after consumption)
//   valid      : dout holds an unconsumed word
//   overrun    : registered one-cycle drop pulse
// ---------------------------------------------------------------------------
module word_holding_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             overrun
);

  // Loading wins over plain consumption: if the old word leaves in the same
  // cycle a new one arrives, valid simply stays high with the new word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        if (!valid || ready) begin
          dout  <= din;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// ---------------------------------------------------------------------------
// serial_deserializer
// Receive end of the single-bit clocked serial link. Frames are
// start(1), WIDTH data bits, [parity], stop(0), every bit qualified by
// inp_valid. Good words go to a one-entry holding register.
// Parameters:
//   WIDTH     : data bits per frame (2..32)
//   MSB_FIRST : 1 = first data bit lands in out[WIDTH-1], 0 = in out[0]
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_deserializer_if.slave (inp/inp_valid in, word handshake
//           and error pulses out)
// Optional feature macro: SERIAL_DESER_PARITY_EN adds an even-parity bit
// between data and stop, plus the parity_err pulse.
// ---------------------------------------------------------------------------
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_deserializer_if.slave bus
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             good_word;
  logic             parity_bad;
  logic [WIDTH-1:0] hold_out;
  logic             hold_valid;
  logic             hold_overrun;

`ifdef SERIAL_DESER_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;

  // Even parity: data bits plus the parity bit must XOR to zero.
  assign parity_bad = (^shift_q) ^ par_q;
`else
  assign parity_bad = 1'b0;
`endif

  // State, bit counter, shift register and error pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= {WIDTH{IDLE_LEVEL}};
      frame_err_q <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
`ifdef SERIAL_DESER_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state and datapath updates. Every branch is gated by inp_valid so
  // a stalled cycle leaves the frame position untouched.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    good_word   = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.inp_valid && bus.inp == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (bus.inp_valid) begin
          if (MSB_FIRST) begin
            shift_d = {shift_q[WIDTH-2:0], bus.inp};
          end else begin
            shift_d = {bus.inp, shift_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_DESER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_DESER_PARITY_EN
      PARITY: begin
        if (bus.inp_valid) begin
          par_d   = bus.inp;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // A bad stop bit masks any parity problem so only one error pulses.
        if (bus.inp_valid) begin
          state_d = IDLE;
          if (bus.inp != STOP_BIT) begin
            frame_err_d = 1'b1;
          end else if (parity_bad) begin
`ifdef SERIAL_DESER_PARITY_EN
            parity_err_d = 1'b1;
`endif
          end else begin
            good_word = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  word_holding_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (good_word),
    .din     (shift_q),
    .ready   (bus.out_ready),
    .dout    (hold_out),
    .valid   (hold_valid),
    .overrun (hold_overrun)
  );

  assign bus.out       = hold_out;
  assign bus.out_valid = hold_valid;
  assign bus.overrun   = hold_overrun;
  assign bus.frame_err = frame_err_q;
`ifdef SERIAL_DESER_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// ---------------------------------------------------------------------------
// tb_serial_deserializer
// Drives two deserializers (MSB_FIRST=1 and MSB_FIRST=0) from the same
// serial stream. Expected words are queued when a frame is sent and popped
// whenever a DUT hands a word over (out_valid && out_ready).
// Honours SERIAL_DESER_PARITY_EN by sending a parity bit per frame.
// ---------------------------------------------------------------------------
module tb_serial_deserializer;

  localparam int WIDTH = 8;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic inp       = 1'b0;
  logic inp_valid = 1'b0;
  logic out_ready = 1'b1;

  int check_count = 0;
  int pass_count  = 0;

  logic [WIDTH-1:0] exp_msb_q[$];
  logic [WIDTH-1:0] exp_lsb_q[$];

  int   frame_err_seen  = 0;
  int   overrun_seen    = 0;
  int   parity_err_seen = 0;
  logic ready_before_stop = 1'b0;

  serial_deserializer_if #(.WIDTH(WIDTH)) bus ();
  serial_deserializer_if #(.WIDTH(WIDTH)) bus_lsb ();

  assign bus.inp           = inp;
  assign bus.inp_valid     = inp_valid;
  assign bus.out_ready     = out_ready;
  assign bus_lsb.inp       = inp;
  assign bus_lsb.inp_valid = inp_valid;
  assign bus_lsb.out_ready = out_ready;

  serial_deserializer #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  serial_deserializer #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_lsb)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] reverse_bits(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] result;
    for (int i = 0; i < WIDTH; i++) result[i] = value[WIDTH-1-i];
    return result;
  endfunction

  // Presents one line cycle; returns just after the sampling edge.
  task automatic applyStimulus(input logic bit_value, input logic bit_valid);
    inp       = bit_value;
    inp_valid = bit_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1);
  endtask

  // Sends one frame, data bits in time order data[7] first. stall_after > 0
  // inserts 4 inp_valid=0 cycles after that many data bits.
  task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop_value,
                            input logic flip_parity, input int stall_after,
                            input logic expect_word);
    logic par_bit;
    par_bit = (^data) ^ flip_parity;
    if (expect_word) begin
      exp_msb_q.push_back(data);
      exp_lsb_q.push_back(reverse_bits(data));
    end
    applyStimulus(1'b1, 1'b1);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(data[i], 1'b1);
      if (WIDTH - i == stall_after) begin
        for (int s = 0; s < 4; s++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
      end
    end
`ifdef SERIAL_DESER_PARITY_EN
    applyStimulus(par_bit, 1'b1);
`endif
    if (ready_before_stop) out_ready = 1'b1;
    applyStimulus(stop_value, 1'b1);
  endtask

  // Scoreboard side: pops an expected word on every accepted transfer and
  // tallies the error pulses one negedge per high cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && out_ready) begin
        if (exp_msb_q.size() == 0) checkOutput("sb_msb_empty", 32'(exp_msb_q.size()), 32'd1);
        else checkOutput("sb_msb_word", 32'(bus.out), 32'(exp_msb_q.pop_front()));
      end
      if (bus_lsb.out_valid && out_ready) begin
        if (exp_lsb_q.size() == 0) checkOutput("sb_lsb_empty", 32'(exp_lsb_q.size()), 32'd1);
        else checkOutput("sb_lsb_word", 32'(bus_lsb.out), 32'(exp_lsb_q.pop_front()));
      end
      frame_err_seen += int'(bus.frame_err);
      overrun_seen   += int'(bus.overrun);
`ifdef SERIAL_DESER_PARITY_EN
      parity_err_seen += int'(bus.parity_err);
`endif
    end
  end

  initial begin
    int fe_base;
    int ov_base;

    // Reset held with the line toggling
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'(i % 2), 1'b1);
    checkOutput("rst_out", 32'(bus.out), 32'h0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_frame_err", 32'(bus.frame_err), 32'h0);
    checkOutput("rst_overrun", 32'(bus.overrun), 32'h0);
    rst_n = 1'b1;
    idle_cycles(2);
    checkOutput("idle_out_valid", 32'(bus.out_valid), 32'h0);

    // Basic frame 0xA5, valid for exactly one cycle
    send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("a5_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("a5_out", 32'(bus.out), 32'hA5);
    idle_cycles(1);
    checkOutput("a5_valid_drop", 32'(bus.out_valid), 32'h0);
    checkOutput("a5_out_hold", 32'(bus.out), 32'hA5);

    // Bit order: 0x01 lands reversed in the LSB-first instance
    send_frame(8'h01, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("x01_msb", 32'(bus.out), 32'h01);
    checkOutput("x01_lsb", 32'(bus_lsb.out), 32'h80);
    idle_cycles(2);

    // Bad stop bit, then a back-to-back good frame
    fe_base = frame_err_seen;
    send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("fe_pulse", 32'(bus.frame_err), 32'h1);
    checkOutput("fe_no_valid", 32'(bus.out_valid), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("b2b_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("b2b_out", 32'(bus.out), 32'h5A);
    checkOutput("fe_len", 32'(frame_err_seen - fe_base), 32'd1);
    idle_cycles(2);

    // Overrun: second word dropped while the first is held
    ov_base   = overrun_seen;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("ovr_pulse", 32'(bus.overrun), 32'h1);
    checkOutput("ovr_out_kept", 32'(bus.out), 32'h11);
    checkOutput("ovr_valid_kept", 32'(bus.out_valid), 32'h1);
    idle_cycles(1);
    checkOutput("ovr_pulse_end", 32'(bus.overrun), 32'h0);
    out_ready = 1'b1;
    idle_cycles(1);
    checkOutput("ovr_drain", 32'(bus.out_valid), 32'h0);
    checkOutput("ovr_count", 32'(overrun_seen - ov_base), 32'd1);

    // Consume and load in the same cycle: no overrun, new word held
    out_ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b0, 0, 1'b1);
    ready_before_stop = 1'b1;
    send_frame(8'h44, 1'b0, 1'b0, 0, 1'b1);
    ready_before_stop = 1'b0;
    checkOutput("swap_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("swap_out", 32'(bus.out), 32'h44);
    checkOutput("swap_no_ovr", 32'(bus.overrun), 32'h0);
    idle_cycles(2);

    // Stall of 4 cycles in the middle of the data bits
    send_frame(8'hC3, 1'b0, 1'b0, 3, 1'b1);
    checkOutput("stall_out", 32'(bus.out), 32'hC3);
    checkOutput("stall_lsb", 32'(bus_lsb.out), 32'hC3);
    idle_cycles(2);

`ifdef SERIAL_DESER_PARITY_EN
    // Wrong parity, then wrong parity and wrong stop together
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("par_pulse", 32'(bus.parity_err), 32'h1);
    checkOutput("par_no_valid", 32'(bus.out_valid), 32'h0);
    idle_cycles(1);
    send_frame(8'h5A, 1'b1, 1'b1, 0, 1'b0);
    checkOutput("both_fe", 32'(bus.frame_err), 32'h1);
    checkOutput("both_no_par", 32'(bus.parity_err), 32'h0);
    checkOutput("par_count", 32'(parity_err_seen), 32'd1);
    idle_cycles(2);
`endif

    // Reset mid-frame discards the partial frame
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1);
    rst_n = 1'b1;
    send_frame(8'h96, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("post_rst_out", 32'(bus.out), 32'h96);
    idle_cycles(3);

    checkOutput("sb_msb_drained", 32'(exp_msb_q.size()), 32'd0);
    checkOutput("sb_lsb_drained", 32'(exp_lsb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
